// File: rtl/vp_pkg.sv
// Shared definitions for the vector processor load/store path.
//   DATA_W     width of one memory word / one vector lane
//   LANES      lanes per vector
//   ADDR_W     memory address width (512 words)
//   RSEL_W     vector register select width
//   VEC_W      full vector width (DATA_W*LANES)
//   lsu_state_e  load/store unit FSM states
//   lsu_op_e     operation encoding (OP_LOAD / OP_STORE)
//   REG_A1..A4   vector register select codes
package vp_pkg;

  localparam int DATA_W     = 32;
  localparam int LANES      = 16;
  localparam int ADDR_W     = 9;
  localparam int RSEL_W     = 2;
  localparam int VEC_W      = DATA_W * LANES;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_RD = 3'd1,
    LOAD_WB = 3'd2,
    ST_SNAP = 3'd3,
    ST_WR   = 3'd4,
    DONE    = 3'd5
  } lsu_state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } lsu_op_e;

  localparam logic [RSEL_W-1:0] REG_A1 = 2'b00;
  localparam logic [RSEL_W-1:0] REG_A2 = 2'b01;
  localparam logic [RSEL_W-1:0] REG_A3 = 2'b10;
  localparam logic [RSEL_W-1:0] REG_A4 = 2'b11;

  // Address of lane idx in a burst; the add wraps modulo the memory size.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [LANE_IDX_W-1:0] idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/vec_load_store_unit.sv
// Vector load/store unit: moves whole 512-bit vectors between the 512x32 word
// memory and the A1..A4 vector register file.
//   LOAD  (op=0): 16 consecutive words from base_addr are assembled into one
//                 vector and written to register reg_sel with a single rf_we.
//   STORE (op=1): register reg_sel is snapshotted and written out as 16
//                 consecutive words starting at base_addr.
// Both operations take 18 cycles from the accepting edge to the done cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op            request (sampled only in IDLE) and operation
//   base_addr, reg_sel   burst start address and vector register
//   busy, done           status; done is a one-cycle pulse
//   mem_addr/mem_wdata/mem_we/mem_rdata   memory port (read data 1 cycle late)
//   rf_rd_sel/rf_rdata                    regfile read port (combinational)
//   rf_we/rf_wr_sel/rf_wdata              regfile write port
module vec_load_store_unit
  import vp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [RSEL_W-1:0] reg_sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [RSEL_W-1:0] rf_rd_sel,
  input  logic [VEC_W-1:0]  rf_rdata,
  output logic              rf_we,
  output logic [RSEL_W-1:0] rf_wr_sel,
  output logic [VEC_W-1:0]  rf_wdata
);

  lsu_state_e              state, state_nxt;
  lsu_op_e                 op_q;
  logic [ADDR_W-1:0]       base_q;
  logic [RSEL_W-1:0]       sel_q;
  logic [LANE_IDX_W-1:0]   lane_cnt;
  logic [LANE_IDX_W-1:0]   cap_idx;
  logic [VEC_W-1:0]        shadow;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  // Read data trails the address by one cycle, so the lane being captured is
  // one behind the lane being addressed. In LOAD_WB the counter has wrapped
  // to 0, which makes this index point at the final lane.
  assign cap_idx = lane_cnt - 1'b1;

  // Next state and outputs. Everything defaults to 0 so that idle and
  // non-enabled cycles present clean zeros on the data buses.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    rf_rd_sel = '0;
    rf_we     = 1'b0;
    rf_wr_sel = '0;
    rf_wdata  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (lsu_op_e'(op) == OP_STORE) ? ST_SNAP : LOAD_RD;
        end
      end
      LOAD_RD: begin
        mem_addr = lane_addr(base_q, lane_cnt);
        if (lane_cnt == LAST_LANE) begin
          state_nxt = LOAD_WB;
        end
      end
      // Drain cycle: the final word arrives here, one cycle after its address.
      LOAD_WB: begin
        state_nxt = DONE;
      end
      ST_SNAP: begin
        rf_rd_sel = sel_q;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = lane_addr(base_q, lane_cnt);
        mem_wdata = shadow[lane_cnt*DATA_W +: DATA_W];
        if (lane_cnt == LAST_LANE) begin
          state_nxt = DONE;
        end
      end
      // Completion cycle; a LOAD commits the assembled vector here so the
      // register write and the done pulse coincide.
      DONE: begin
        done = 1'b1;
        if (op_q == OP_LOAD) begin
          rf_we     = 1'b1;
          rf_wr_sel = sel_q;
          rf_wdata  = shadow;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, request latch, lane counter and shadow/assembly vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_LOAD;
      base_q   <= '0;
      sel_q    <= '0;
      lane_cnt <= '0;
      shadow   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= lsu_op_e'(op);
            base_q   <= base_addr;
            sel_q    <= reg_sel;
            lane_cnt <= '0;
          end
        end
        LOAD_RD: begin
          lane_cnt <= lane_cnt + 1'b1;
          if (lane_cnt != '0) begin
            shadow[cap_idx*DATA_W +: DATA_W] <= mem_rdata;
          end
        end
        LOAD_WB: begin
          shadow[cap_idx*DATA_W +: DATA_W] <= mem_rdata;
        end
        ST_SNAP: begin
          shadow <= rf_rdata;
        end
        ST_WR: begin
          lane_cnt <= lane_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_load_store_unit.sv
// Directed bench for vec_load_store_unit with a registered-read memory model
// and a four-entry vector register file model.
module tb_vec_load_store_unit;
  import vp_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              op = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [RSEL_W-1:0] reg_sel = '0;
  logic              busy, done, mem_we, rf_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [RSEL_W-1:0] rf_rd_sel, rf_wr_sel;
  logic [VEC_W-1:0]  rf_rdata, rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr),
    .reg_sel(reg_sel), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .rf_rd_sel(rf_rd_sel), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_wr_sel(rf_wr_sel), .rf_wdata(rf_wdata)
  );

  // Memory model: registered read, preload port for the bench.
  logic [DATA_W-1:0] tb_mem [512];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    else if (pre_we) tb_mem[pre_addr] <= pre_data;
    mem_rdata <= tb_mem[mem_addr];
  end

  // Register file model: combinational read.
  logic [VEC_W-1:0]  tb_rf [4];
  logic              pre_rf_we = 1'b0;
  logic [RSEL_W-1:0] pre_rf_sel = '0;
  logic [VEC_W-1:0]  pre_rf_data = '0;
  always @(posedge clk) begin
    if (rf_we) tb_rf[rf_wr_sel] <= rf_wdata;
    else if (pre_rf_we) tb_rf[pre_rf_sel] <= pre_rf_data;
  end
  assign rf_rdata = tb_rf[rf_rd_sel];

  // Per-cycle observations of one operation, index = cycle after acceptance.
  logic              c_busy [21];
  logic              c_done [21];
  logic              c_mwe  [21];
  logic [ADDR_W-1:0] c_maddr[21];
  logic [DATA_W-1:0] c_mwd  [21];
  logic              c_rfwe [21];
  logic [RSEL_W-1:0] c_rfsel[21];
  logic [VEC_W-1:0]  c_rfwd [21];
  logic [RSEL_W-1:0] c_rdsel[21];
  logic              pre_busy;
  logic              rst_busy;
  logic              rst_any;

  function automatic logic [VEC_W-1:0] make_vec(input logic [31:0] seed, input logic [31:0] step);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[32*i +: 32] = seed + step * 32'(i);
    return v;
  endfunction

  task automatic preload_mem(input logic [ADDR_W-1:0] b, input logic [31:0] seed, input logic [31:0] step);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = b + 9'(i);
      pre_data = seed + step * 32'(i);
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload_rf(input logic [RSEL_W-1:0] s, input logic [VEC_W-1:0] v);
    @(negedge clk);
    pre_rf_we = 1'b1; pre_rf_sel = s; pre_rf_data = v;
    @(negedge clk);
    pre_rf_we = 1'b0;
  endtask

  // Issues one request and records cycles T1..T18. Optionally pulses a
  // conflicting start in cycle pulse_at, or asserts reset in cycle rst_at.
  task automatic run_op(input logic o, input logic [ADDR_W-1:0] b, input logic [RSEL_W-1:0] s,
                        input int pulse_at, input int rst_at);
    @(negedge clk);
    pre_busy = busy;
    start = 1'b1; op = o; base_addr = b; reg_sel = s;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      c_busy[k] = busy; c_done[k] = done; c_mwe[k] = mem_we; c_maddr[k] = mem_addr;
      c_mwd[k] = mem_wdata; c_rfwe[k] = rf_we; c_rfsel[k] = rf_wr_sel; c_rfwd[k] = rf_wdata;
      c_rdsel[k] = rf_rd_sel;
      start = 1'b0;
      if (k == pulse_at) begin
        start = 1'b1; op = ~o; base_addr = 9'h100; reg_sel = ~s;
      end
      if (rst_at > 0 && k == rst_at) begin
        rst_n = 1'b0;
        #1;
        rst_busy = busy;
        rst_any = mem_we | rf_we | done | (|mem_addr) | (|rf_wr_sel) | (|rf_rd_sel)
                  | (|mem_wdata) | (|rf_wdata);
      end
      if (rst_at > 0 && k == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if ({mem_we, rf_we} !== 2'b00) begin errors++; $display("FAIL reset_we got %b expected 00", {mem_we, rf_we}); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem got addr %h data %h expected 0", mem_addr, mem_wdata); end
    checks++; if (rf_wdata !== '0 || rf_wr_sel !== '0 || rf_rd_sel !== '0) begin errors++; $display("FAIL reset_rf got wsel %h rsel %h expected 0", rf_wr_sel, rf_rd_sel); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_load_basic();
    logic [VEC_W-1:0] exp_v;
    exp_v = make_vec(32'h1000_0000, 32'd1);
    preload_mem(9'h010, 32'h1000_0000, 32'd1);
    run_op(1'b0, 9'h010, REG_A2, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      checks++; if (c_busy[k] !== 1'b1) begin errors++; $display("FAIL load_busy T%0d got %b expected 1", k, c_busy[k]); end
      checks++; if (c_done[k] !== (k == 18)) begin errors++; $display("FAIL load_done T%0d got %b expected %b", k, c_done[k], k == 18); end
      checks++; if (c_rfwe[k] !== (k == 18)) begin errors++; $display("FAIL load_rf_we T%0d got %b expected %b", k, c_rfwe[k], k == 18); end
      checks++; if (c_mwe[k] !== 1'b0) begin errors++; $display("FAIL load_mem_we T%0d got %b expected 0", k, c_mwe[k]); end
      if (k <= 16) begin
        checks++; if (c_maddr[k] !== 9'(9'h010 + k - 1)) begin errors++; $display("FAIL load_addr T%0d got %h expected %h", k, c_maddr[k], 9'(9'h010 + k - 1)); end
      end
      if (k < 18) begin
        checks++; if (c_rfwd[k] !== '0) begin errors++; $display("FAIL load_rf_wdata_idle T%0d got nonzero expected 0", k); end
      end
    end
    checks++; if (c_rfsel[18] !== REG_A2) begin errors++; $display("FAIL load_wr_sel got %h expected %h", c_rfsel[18], REG_A2); end
    checks++; if (c_rfwd[18] !== exp_v) begin errors++; $display("FAIL load_wdata got %h expected %h", c_rfwd[18], exp_v); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL load_T19 got busy %b done %b expected 0 0", busy, done); end
    checks++; if (tb_rf[1] !== exp_v) begin errors++; $display("FAIL load_rf_A2 got %h expected %h", tb_rf[1], exp_v); end
  endtask

  task automatic test_store_basic();
    logic [VEC_W-1:0] v;
    v = make_vec(32'hA5A5_0000, 32'd1);
    preload_rf(REG_A3, v);
    run_op(1'b1, 9'h020, REG_A3, 0, 0);
    checks++; if (c_rdsel[1] !== REG_A3) begin errors++; $display("FAIL store_rd_sel got %h expected %h", c_rdsel[1], REG_A3); end
    for (int k = 1; k <= 18; k++) begin
      checks++; if (c_mwe[k] !== (k >= 2 && k <= 17)) begin errors++; $display("FAIL store_mem_we T%0d got %b expected %b", k, c_mwe[k], k >= 2 && k <= 17); end
      checks++; if (c_done[k] !== (k == 18)) begin errors++; $display("FAIL store_done T%0d got %b expected %b", k, c_done[k], k == 18); end
      checks++; if (c_rfwe[k] !== 1'b0) begin errors++; $display("FAIL store_rf_we T%0d got %b expected 0", k, c_rfwe[k]); end
      if (k >= 2 && k <= 17) begin
        checks++; if (c_maddr[k] !== 9'(9'h020 + k - 2)) begin errors++; $display("FAIL store_addr T%0d got %h expected %h", k, c_maddr[k], 9'(9'h020 + k - 2)); end
        checks++; if (c_mwd[k] !== 32'hA5A5_0000 + 32'(k - 2)) begin errors++; $display("FAIL store_wdata T%0d got %h expected %h", k, c_mwd[k], 32'hA5A5_0000 + 32'(k - 2)); end
      end else begin
        checks++; if (c_mwd[k] !== '0) begin errors++; $display("FAIL store_wdata_idle T%0d got %h expected 0", k, c_mwd[k]); end
      end
    end
    @(negedge clk);
    for (int i = 0; i < LANES; i++) begin
      checks++; if (tb_mem[9'h020 + 9'(i)] !== 32'hA5A5_0000 + 32'(i)) begin errors++; $display("FAIL store_mem[%0d] got %h expected %h", i, tb_mem[9'h020 + 9'(i)], 32'hA5A5_0000 + 32'(i)); end
    end
  endtask

  task automatic test_wrap();
    logic [VEC_W-1:0] exp_v;
    logic [ADDR_W-1:0] ea;
    exp_v = make_vec(32'h5A00_0000, 32'd1);
    preload_mem(9'h1F8, 32'h5A00_0000, 32'd1);
    run_op(1'b0, 9'h1F8, REG_A1, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      ea = 9'h1F8 + 9'(k - 1);
      checks++; if (c_maddr[k] !== ea) begin errors++; $display("FAIL wrap_addr T%0d got %h expected %h", k, c_maddr[k], ea); end
    end
    checks++; if (c_rfwd[18][8*32 +: 32] !== 32'h5A00_0008) begin errors++; $display("FAIL wrap_lane8 got %h expected 5a000008", c_rfwd[18][8*32 +: 32]); end
    checks++; if (c_rfwd[18] !== exp_v) begin errors++; $display("FAIL wrap_vec got %h expected %h", c_rfwd[18], exp_v); end
    @(negedge clk);
  endtask

  task automatic test_busy_latch_back_to_back();
    logic [VEC_W-1:0] exp_v;
    exp_v = make_vec(32'h7700_0000, 32'd1);
    preload_mem(9'h040, 32'h7700_0000, 32'd1);
    run_op(1'b0, 9'h040, REG_A4, 5, 0);
    for (int k = 1; k <= 16; k++) begin
      checks++; if (c_maddr[k] !== 9'(9'h040 + k - 1)) begin errors++; $display("FAIL latch_addr T%0d got %h expected %h", k, c_maddr[k], 9'(9'h040 + k - 1)); end
    end
    for (int k = 1; k <= 18; k++) begin
      checks++; if (c_mwe[k] !== 1'b0 || c_rfwe[k] !== (k == 18)) begin errors++; $display("FAIL latch_we T%0d got mem %b rf %b expected 0 %b", k, c_mwe[k], c_rfwe[k], k == 18); end
    end
    checks++; if (c_rfsel[18] !== REG_A4 || c_rfwd[18] !== exp_v) begin errors++; $display("FAIL latch_wb got sel %h data %h expected %h %h", c_rfsel[18], c_rfwd[18], REG_A4, exp_v); end
    // Start presented in T19: must be accepted immediately.
    run_op(1'b1, 9'h080, REG_A4, 0, 0);
    checks++; if (pre_busy !== 1'b0) begin errors++; $display("FAIL b2b_T19_busy got %b expected 0", pre_busy); end
    checks++; if (c_busy[1] !== 1'b1 || c_rdsel[1] !== REG_A4) begin errors++; $display("FAIL b2b_accept got busy %b sel %h expected 1 %h", c_busy[1], c_rdsel[1], REG_A4); end
    for (int k = 2; k <= 17; k++) begin
      checks++; if (c_mwe[k] !== 1'b1 || c_maddr[k] !== 9'(9'h080 + k - 2) || c_mwd[k] !== 32'h7700_0000 + 32'(k - 2)) begin
        errors++; $display("FAIL b2b_write T%0d got we %b addr %h data %h expected 1 %h %h", k, c_mwe[k], c_maddr[k], c_mwd[k], 9'(9'h080 + k - 2), 32'h7700_0000 + 32'(k - 2));
      end
    end
    checks++; if (c_done[18] !== 1'b1) begin errors++; $display("FAIL b2b_done got %b expected 1", c_done[18]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [VEC_W-1:0] keep_v, exp_v;
    keep_v = make_vec(32'h3333_0000, 32'd1);
    exp_v  = make_vec(32'h6600_0000, 32'h0000_0100);
    preload_rf(REG_A3, keep_v);
    preload_mem(9'h060, 32'h6600_0000, 32'h0000_0100);
    run_op(1'b0, 9'h060, REG_A3, 0, 10);
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", rst_busy); end
    checks++; if (rst_any !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got %b expected 0", rst_any); end
    for (int k = 11; k <= 18; k++) begin
      checks++; if (c_busy[k] !== 1'b0 || c_done[k] !== 1'b0 || c_rfwe[k] !== 1'b0) begin
        errors++; $display("FAIL rstmid_after T%0d got busy %b done %b rf_we %b expected 0 0 0", k, c_busy[k], c_done[k], c_rfwe[k]);
      end
    end
    checks++; if (tb_rf[2] !== keep_v) begin errors++; $display("FAIL rstmid_rf got %h expected %h", tb_rf[2], keep_v); end
    run_op(1'b0, 9'h060, REG_A3, 0, 0);
    checks++; if (c_done[18] !== 1'b1 || c_done[17] !== 1'b0 || c_rfwe[18] !== 1'b1) begin
      errors++; $display("FAIL rstmid_fresh_done got done17 %b done18 %b rf_we %b expected 0 1 1", c_done[17], c_done[18], c_rfwe[18]);
    end
    @(negedge clk);
    checks++; if (tb_rf[2] !== exp_v) begin errors++; $display("FAIL rstmid_fresh_rf got %h expected %h", tb_rf[2], exp_v); end
  endtask

  task automatic test_round_trip();
    logic [VEC_W-1:0] v;
    v = make_vec(32'h0BAD_F00D, 32'h0101_0101);
    preload_rf(REG_A1, v);
    run_op(1'b1, 9'h1F0, REG_A1, 0, 0);
    run_op(1'b0, 9'h1F0, REG_A4, 0, 0);
    checks++; if (c_done[18] !== 1'b1) begin errors++; $display("FAIL rt_done got %b expected 1", c_done[18]); end
    @(negedge clk);
    checks++; if (tb_rf[3] !== v) begin errors++; $display("FAIL rt_A4 got %h expected %h", tb_rf[3], v); end
    checks++; if (tb_rf[0] !== v) begin errors++; $display("FAIL rt_A1 got %h expected %h", tb_rf[0], v); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_basic();
    test_wrap();
    test_busy_latch_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
